// File: rtl/gpca_pkg.sv
// Shared constants and types for the gpca cellular-array front end.
package gpca_pkg;

  localparam int unsigned GPCA_ROWS = 9;
  localparam int unsigned GPCA_AW   = 18;
  localparam int unsigned GPCA_BW   = 19;

  // Operand beat order on the input stream.
  localparam logic [1:0] BEAT_A = 2'd0;
  localparam logic [1:0] BEAT_B = 2'd1;
  localparam logic [1:0] BEAT_C = 2'd2;
  localparam logic [1:0] BEAT_P = 2'd3;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } gpca_state_e;

endpackage

// File: rtl/gpca_loader.sv
// Operand sequencer and result capture for the combinational gpca array.
// Four operand beats (A, B, C, P/X) are loaded into registers driving the
// array, the array is allowed SETTLE_CYC cycles to settle, then F/S are
// captured and offered on a valid/ready output stream.
// Optional feature: define GPCA_LOADER_PARITY_EN to add the out_par output.
module gpca_loader
  import gpca_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [19:0]          in_data,
  output logic                 g_x,
  output logic [GPCA_ROWS-1:0] g_p,
  output logic [GPCA_AW-1:0]   g_a,
  output logic [GPCA_BW-1:0]   g_b,
  output logic [GPCA_BW-1:0]   g_c,
  input  logic [GPCA_ROWS-1:0] g_f,
  input  logic [GPCA_BW-1:0]   g_s,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [GPCA_ROWS-1:0] out_f,
  output logic [GPCA_BW-1:0]   out_s
`ifdef GPCA_LOADER_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

  gpca_state_e          state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [3:0]           settle_q, settle_d;
  logic                 in_ready_q, in_ready_d;
  logic                 g_x_q, g_x_d;
  logic [GPCA_ROWS-1:0] g_p_q, g_p_d;
  logic [GPCA_AW-1:0]   g_a_q, g_a_d;
  logic [GPCA_BW-1:0]   g_b_q, g_b_d;
  logic [GPCA_BW-1:0]   g_c_q, g_c_d;
  logic                 out_valid_q, out_valid_d;
  logic [GPCA_ROWS-1:0] out_f_q, out_f_d;
  logic [GPCA_BW-1:0]   out_s_q, out_s_d;
`ifdef GPCA_LOADER_PARITY_EN
  logic                 out_par_q, out_par_d;
`endif

  // State, counters, array operand registers and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      beat_q      <= '0;
      settle_q    <= '0;
      in_ready_q  <= 1'b1;
      g_x_q       <= 1'b0;
      g_p_q       <= '0;
      g_a_q       <= '0;
      g_b_q       <= '0;
      g_c_q       <= '0;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_s_q     <= '0;
`ifdef GPCA_LOADER_PARITY_EN
      out_par_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      settle_q    <= settle_d;
      in_ready_q  <= in_ready_d;
      g_x_q       <= g_x_d;
      g_p_q       <= g_p_d;
      g_a_q       <= g_a_d;
      g_b_q       <= g_b_d;
      g_c_q       <= g_c_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_s_q     <= out_s_d;
`ifdef GPCA_LOADER_PARITY_EN
      out_par_q   <= out_par_d;
`endif
    end
  end

  // Next-state: beat steering in LOAD, settle countdown, output handshake.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    settle_d    = settle_q;
    g_x_d       = g_x_q;
    g_p_d       = g_p_q;
    g_a_d       = g_a_q;
    g_b_d       = g_b_q;
    g_c_d       = g_c_q;
    out_valid_d = out_valid_q;
    out_f_d     = out_f_q;
    out_s_d     = out_s_q;
`ifdef GPCA_LOADER_PARITY_EN
    out_par_d   = out_par_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (in_valid && in_ready_q) begin
          beat_d = beat_q + 2'd1;
          unique case (beat_q)
            BEAT_A: g_a_d = in_data[GPCA_AW-1:0];
            BEAT_B: g_b_d = in_data[GPCA_BW-1:0];
            BEAT_C: g_c_d = in_data[GPCA_BW-1:0];
            BEAT_P: begin
              g_p_d    = in_data[GPCA_ROWS-1:0];
              g_x_d    = in_data[19];
              settle_d = SETTLE_INIT;
              state_d  = SETTLE;
            end
          endcase
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          out_f_d     = g_f;
          out_s_d     = g_s;
          out_valid_d = 1'b1;
`ifdef GPCA_LOADER_PARITY_EN
          out_par_d   = ^{g_f, g_s};
`endif
          state_d     = HOLD;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    // Registered ready: high exactly while the block sits in LOAD.
    in_ready_d = (state_d == LOAD);
  end

  assign in_ready  = in_ready_q;
  assign g_x       = g_x_q;
  assign g_p       = g_p_q;
  assign g_a       = g_a_q;
  assign g_b       = g_b_q;
  assign g_c       = g_c_q;
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;
  assign out_s     = out_s_q;
`ifdef GPCA_LOADER_PARITY_EN
  assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_gpca_loader.sv
// Directed bench for gpca_loader with a stub array (S = B ^ C, F = P).
// Honours GPCA_LOADER_PARITY_EN when defined.
module tb_gpca_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, in_ready, out_valid;
  logic [19:0] in_data;
  logic        g_x;
  logic [8:0]  g_p, g_f, out_f;
  logic [17:0] g_a;
  logic [18:0] g_b, g_c, g_s, out_s;
`ifdef GPCA_LOADER_PARITY_EN
  logic        out_par;
`endif

  assign g_s = g_b ^ g_c;
  assign g_f = g_p;

  gpca_loader #(.SETTLE_CYC(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .g_x(g_x), .g_p(g_p), .g_a(g_a), .g_b(g_b), .g_c(g_c), .g_f(g_f), .g_s(g_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_s(out_s)
`ifdef GPCA_LOADER_PARITY_EN
    , .out_par(out_par)
`endif
  );

  // Settle-length sweep instances sharing one stimulus stream.
  logic        sw_valid, sw_ready;
  logic [19:0] sw_data;
  logic        r1, r15, v1, v15, x1, x15;
  logic [8:0]  p1, p15, of1, of15;
  logic [17:0] a1, a15;
  logic [18:0] b1, b15, c1, c15, os1, os15;
`ifdef GPCA_LOADER_PARITY_EN
  logic        par1, par15;
`endif

  gpca_loader #(.SETTLE_CYC(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1), .in_data(sw_data),
    .g_x(x1), .g_p(p1), .g_a(a1), .g_b(b1), .g_c(c1), .g_f(p1), .g_s(b1 ^ c1),
    .out_valid(v1), .out_ready(sw_ready), .out_f(of1), .out_s(os1)
`ifdef GPCA_LOADER_PARITY_EN
    , .out_par(par1)
`endif
  );

  gpca_loader #(.SETTLE_CYC(15)) u_s15 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r15), .in_data(sw_data),
    .g_x(x15), .g_p(p15), .g_a(a15), .g_b(b15), .g_c(c15), .g_f(p15), .g_s(b15 ^ c15),
    .out_valid(v15), .out_ready(sw_ready), .out_f(of15), .out_s(os15)
`ifdef GPCA_LOADER_PARITY_EN
    , .out_par(par15)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [19:0] a_raw, b_raw, c_raw, px_raw;
    logic [17:0] exp_a;
    logic [18:0] exp_b, exp_c;
    logic [8:0]  exp_p;
    logic        exp_x;
    logic [18:0] exp_s;
    logic [8:0]  exp_f;
    logic        exp_par;
    bit          gap;
  } vec_t;

  vec_t vecs[6];

  // One beat: optional idle cycle first, then hold valid until accepted.
  task automatic send_beat(input logic [19:0] d, input bit gap);
    bit done = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Full transaction with out_ready already high.
  task automatic run_vec(input vec_t v, input int idx);
    int k = 0;
    send_beat(v.a_raw, v.gap);
    send_beat(v.b_raw, v.gap);
    send_beat(v.c_raw, v.gap);
    send_beat(v.px_raw, v.gap);
    chk($sformatf("v%0d_g_a", idx), 32'(g_a), 32'(v.exp_a));
    chk($sformatf("v%0d_g_b", idx), 32'(g_b), 32'(v.exp_b));
    chk($sformatf("v%0d_g_c", idx), 32'(g_c), 32'(v.exp_c));
    chk($sformatf("v%0d_g_p", idx), 32'(g_p), 32'(v.exp_p));
    chk($sformatf("v%0d_g_x", idx), 32'(g_x), 32'(v.exp_x));
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(k), 32'd2);
    chk($sformatf("v%0d_out_s", idx), 32'(out_s), 32'(v.exp_s));
    chk($sformatf("v%0d_out_f", idx), 32'(out_f), 32'(v.exp_f));
`ifdef GPCA_LOADER_PARITY_EN
    chk($sformatf("v%0d_out_par", idx), 32'(out_par), 32'(v.exp_par));
`endif
    @(posedge clk); #1;
    chk($sformatf("v%0d_valid_clr", idx), 32'(out_valid), 32'd0);
    chk($sformatf("v%0d_ready_back", idx), 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{20'h00001, 20'h7FFFF, 20'h00F0F, 20'h80155, 18'h00001, 19'h7FFFF, 19'h00F0F,
                9'h155, 1'b1, 19'h7F0F0, 9'h155, 1'b0, 1'b0};
    vecs[1] = '{20'hFFFFF, 20'h92345, 20'hD4321, 20'hFFEAA, 18'h3FFFF, 19'h12345, 19'h54321,
                9'h0AA, 1'b1, 19'h46064, 9'h0AA, 1'b0, 1'b1};
    vecs[2] = '{20'h00000, 20'h00000, 20'h00000, 20'h00000, 18'h00000, 19'h00000, 19'h00000,
                9'h000, 1'b0, 19'h00000, 9'h000, 1'b0, 1'b0};
    vecs[3] = '{20'h2AAAA, 20'h55555, 20'h2AAAA, 20'hFFFFF, 18'h2AAAA, 19'h55555, 19'h2AAAA,
                9'h1FF, 1'b1, 19'h7FFFF, 9'h1FF, 1'b0, 1'b1};
    vecs[4] = vecs[0];
    vecs[4].gap = 1'b1;
    vecs[5] = '{20'h00000, 20'h00001, 20'h00000, 20'h00000, 18'h00000, 19'h00001, 19'h00000,
                9'h000, 1'b0, 19'h00001, 9'h000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_data = '0; sw_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_s", 32'(out_s), 32'd0);
    chk("rst_out_f", 32'(out_f), 32'd0);
    chk("rst_g_all", 32'({g_x, g_p, g_a[0], g_b[0], g_c[0]}), 32'd0);
`ifdef GPCA_LOADER_PARITY_EN
    chk("rst_out_par", 32'(out_par), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Output backpressure with a new beat waiting.
    out_ready = 1'b0;
    send_beat(20'h00001, 1'b0);
    send_beat(20'h7FFFF, 1'b0);
    send_beat(20'h00F0F, 1'b0);
    send_beat(20'h80155, 1'b0);
    for (int k = 0; k < 40 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_up", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 20'h00123;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_s", 32'(out_s), 32'h7F0F0);
      chk("bp_g_a_held", 32'(g_a), 32'h00001);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid_clr", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    chk("hs_no_early_beat", 32'(g_a), 32'h00001);
    @(posedge clk); #1;
    chk("post_hs_beat_a", 32'(g_a), 32'h00123);
    in_data = 20'h00456;
    @(posedge clk); #1;
    chk("post_hs_beat_b", 32'(g_b), 32'h00456);
    in_data = 20'h00789;
    @(posedge clk); #1;
    chk("post_hs_beat_c", 32'(g_c), 32'h00789);
    in_valid = 1'b0;

    // Reset after beat 2 discards the partial load.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_g_a", 32'(g_a), 32'd0);
    chk("mid_rst_g_b", 32'(g_b), 32'd0);
    chk("mid_rst_g_c", 32'(g_c), 32'd0);
    chk("mid_rst_g_px", 32'({g_x, g_p}), 32'd0);
    chk("mid_rst_out", 32'({out_valid, out_f, out_s[0]}), 32'd0);
    chk("mid_rst_out_s", 32'(out_s), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    run_vec(vecs[0], 10);

    // Settle-length sweep on the SETTLE_CYC=1 and 15 instances.
    begin
      int lat1 = 0;
      int lat15 = 0;
      logic [19:0] beats[4];
      beats[0] = 20'h00000; beats[1] = 20'h0000F; beats[2] = 20'h000F0; beats[3] = 20'h00003;
      chk("sw_ready_both", 32'({r1, r15}), 32'd3);
      sw_valid = 1'b1;
      for (int b = 0; b < 4; b++) begin
        sw_data = beats[b];
        @(posedge clk); #1;
      end
      sw_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
        @(posedge clk); #1;
        if (v1 && lat1 == 0) lat1 = k;
        if (v15 && lat15 == 0) lat15 = k;
      end
      chk("sweep_lat_1", 32'(lat1), 32'd1);
      chk("sweep_lat_15", 32'(lat15), 32'd15);
      chk("sweep_s1_out_s", 32'(os1), 32'h000FF);
      chk("sweep_s15_out", 32'({of15, os15}), 32'({9'h003, 19'h000FF}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpca_loader.md
# gpca_loader

Operand sequencer and result-capture stage in front of the 9-row `gpca` cellular array. It accepts operands as four beats on a valid/ready stream and holds them in registers that drive the array's inputs. Because the array is purely combinational, the block waits a programmable number of settle cycles before capturing its quotient/control bits `F` and sum word `S`. The captured result is offered on a valid/ready output stream.

## Interface
- `SETTLE_CYC`, default 2: cycles between driving the last operand and capturing the result; legal range 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  20  operand beat payload.
- `g_x`  out  1  array mode bit X.
- `g_p`  out  9  array P; bit 8 drives P[1].
- `g_a`  out  18  array A; bit 17 drives A[1].
- `g_b`  out  19  array B; bit 18 drives B[1].
- `g_c`  out  19  array C; bit 18 drives C[1].
- `g_f`  in  9  array F; bit 8 is F[1].
- `g_s`  in  19  array S; bit 18 is S[1].
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_f`  out  9  captured F.
- `out_s`  out  19  captured S.
- `out_par`  out  1  parity bit; present only with `GPCA_LOADER_PARITY_EN`.

## Operation
- **Beat order:** beat 0 is A (`in_data[17:0]`), beat 1 is B (`[18:0]`), beat 2 is C (`[18:0]`), beat 3 is P (`[8:0]`) with X (`[19]`). Payload bits outside each field are ignored.
- **Beat acceptance:** a beat is accepted when `in_valid && in_ready`. It is written directly into the matching `g_*` register on that edge.
- **State machine:** states LOAD, SETTLE, HOLD.
  - **LOAD:** `in_ready=1`. A 2-bit beat counter advances on each accepted beat. When beat 3 is accepted, the counter returns to 0, the settle counter loads `SETTLE_CYC-1`, and the state goes to SETTLE.
  - **SETTLE:** `in_ready=0`. The counter decrements each cycle. When it reaches 0, `g_f`/`g_s` are captured into `out_f`/`out_s`, `out_valid` is set, and the state goes to HOLD.
  - **HOLD:** `in_ready=0`. `out_valid=1`, and `out_f`/`out_s` are stable. On `out_ready`, `out_valid` clears and the state returns to LOAD.
- **Array inputs:** the `g_*` registers keep their values through SETTLE and HOLD, and until they are overwritten by the next beat.
- **Bit ordering:** the MSB of every `g_*` bus maps to the array's index 1.
- **Reset:** the state goes to LOAD and the beat counter to 0. All `g_*`, `out_f`, `out_s` and `out_par` go to 0; `out_valid=0` and `in_ready=1`.
- **Reset mid-operation:** a partial load or pending result is discarded without trace.

## Timing
- **Latency:** beat 3 is accepted on edge E0. Capture and the rise of `out_valid` happen on edge E0+`SETTLE_CYC`, so the array sees stable inputs for at least `SETTLE_CYC` full cycles.
- **Throughput:** one result per 4 + `SETTLE_CYC` + 1 cycles minimum, when `in_valid` and `out_ready` are held high.
- **Output handshake cycle:** `in_ready` is low during the cycle in which the output handshake completes. The first beat of the next operand is accepted no earlier than the following cycle.
- **Input stalls:** a gap in `in_valid` during LOAD stalls the beat counter. Beats already loaded are held indefinitely.
- **Output stalls:** `out_ready` low in HOLD stalls the block indefinitely; the output values do not change.
- **Pre-asserted ready:** `out_ready` asserted before `out_valid` has no effect.
- **`in_ready`:** registered; it is a function of state only.

## Configuration
- **`GPCA_LOADER_PARITY_EN` defined:** `out_par` is registered at capture as the XOR of all 28 bits of {`g_f`,`g_s`}. It is 0 after reset.
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Structure
- **Package `gpca_pkg`:** holds the array width constants `GPCA_ROWS=9`, `GPCA_AW=18` and `GPCA_BW=19`. It also holds the state enum (LOAD, SETTLE, HOLD) and the beat index constants.
- **Hierarchy:** no sub-module. The `gpca` array is instantiated by the parent, not inside this block.

## Test plan
The bench uses a stub array with `g_s = g_b ^ g_c` and `g_f = g_p`.

- **Basic transaction:** with reset then beats A=0x00001, B=0x7FFFF, C=0x00F0F, P/X=0x80155, and `out_ready=1`, `out_valid` rises 2 cycles after beat 3. The response is `out_s`=0x7F0F0, `out_f`=0x155, and the `g_x` probe reads 1.
- **Input gaps:** `in_valid` toggled 1-0-1 between every beat gives the same result. Latency is unchanged after beat 3, and no beat is lost or duplicated.
- **Output backpressure:** hold `out_ready=0` for 10 cycles while driving a new `in_valid` beat. Required: `in_ready` stays 0, outputs stay stable, and the beat is accepted only on the cycle after the handshake.
- **Reset mid-load:** assert `rst` after beat 2. Required: all outputs are 0 and `in_ready=1` on the next cycle. A fresh 4-beat load then produces a correct result.
- **Settle-length sweep:** `SETTLE_CYC`=1 and 15 give `out_valid` exactly 1 and 15 cycles after beat 3.
- **Parity:** with `GPCA_LOADER_PARITY_EN` defined, `out_s`=0x00001 and `out_f`=0 give `out_par`=1; all-zero operands give `out_par`=0.
